// File: rtl/alu_seq_pipe.sv
// ---------------------------------------------------------------------------
// alu_seq_pipe
//   Registered WIDTH-bit ALU with valid/ready handshakes on both sides. It
//   sits between the operand mux and the accumulator writeback. Most opcodes
//   finish in one cycle. MUL (shift-add) and DIV (restoring shift-subtract)
//   iterate one bit per cycle. Only one operation is in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand/opcode bundle valid
//   in_ready     block can accept a bundle (registered)
//   operand_a    first operand
//   operand_b    second operand
//   operation    4-bit opcode
//   out_valid    result bundle valid (registered)
//   out_ready    consumer accepts result
//   result       operation result
//   carry_out    carry / borrow / shifted-out bit / MUL high-half nonzero
//   zero         result == 0
//   sign         result MSB
//   overflow     two's-complement overflow of ADD/SUB
//   div_by_zero  DIV issued with operand_b == 0
// ---------------------------------------------------------------------------
module alu_seq_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             sign,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             sign_reg;
    logic             overflow_reg;
    logic             dbz_reg;

    // Iterative datapath: a_reg is the multiplicand, b_reg the divisor.
    // hi_reg/lo_reg form a 2*WIDTH shift register: for MUL it holds the
    // partial product with the multiplier in the low half; for DIV it holds
    // the partial remainder (hi) and the dividend/quotient (lo).
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg;

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    // ---------------- single-cycle operations ----------------
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_v[gi] = operand_a[gi] & operand_b[gi];
            assign or_v[gi]  = operand_a[gi] | operand_b[gi];
            assign xor_v[gi] = operand_a[gi] ^ operand_b[gi];
        end
    endgenerate

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_dbz;
    logic             start_iter;

    assign sum_w  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff_w = {1'b0, operand_a} - {1'b0, operand_b};

    // MUL always iterates; DIV iterates unless the divisor is zero, in which
    // case the saturated result below is returned in a single cycle.
    assign start_iter = (operation == OP_MUL) ||
                        ((operation == OP_DIV) && (operand_b != '0));

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_dbz   = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
                alu_ovf   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                            (sum_w[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
                alu_ovf   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                            (diff_w[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_MUL: ;
            OP_DIV: begin
                alu_res = '1;
                alu_dbz = 1'b1;
            end
            OP_SHL: begin
                alu_res   = {operand_a[WIDTH-2:0], 1'b0};
                alu_carry = operand_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, operand_a[WIDTH-1:1]};
                alu_carry = operand_a[0];
            end
            OP_ROL: begin
                alu_res   = {operand_a[WIDTH-2:0], operand_a[WIDTH-1]};
                alu_carry = operand_a[WIDTH-1];
            end
            OP_ROR: begin
                alu_res   = {operand_a[0], operand_a[WIDTH-1:1]};
                alu_carry = operand_a[0];
            end
            OP_AND:  alu_res = and_v;
            OP_OR:   alu_res = or_v;
            OP_XOR:  alu_res = xor_v;
            OP_NOR:  alu_res = ~or_v;
            OP_NAND: alu_res = ~and_v;
            OP_XNOR: alu_res = ~xor_v;
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (operand_a > operand_b)};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (operand_a == operand_b)};
            default: ;
        endcase
    end

    // ---------------- one MUL / DIV iteration ----------------
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    logic           div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_trial = div_shift - {1'b0, b_reg};
        if (is_div_reg) begin
            // Remainder stays below the divisor, so WIDTH bits always suffice.
            hi_next = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // ---------------- control FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            dbz_reg       <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            cnt_reg       <= '0;
            is_div_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        if (start_iter) begin
                            state_reg  <= BUSY;
                            cnt_reg    <= '0;
                            a_reg      <= operand_a;
                            b_reg      <= operand_b;
                            is_div_reg <= (operation == OP_DIV);
                            hi_reg     <= '0;
                            lo_reg     <= (operation == OP_DIV) ? operand_a : operand_b;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= alu_res;
                            carry_reg     <= alu_carry;
                            zero_reg      <= (alu_res == '0);
                            sign_reg      <= alu_res[WIDTH-1];
                            overflow_reg  <= alu_ovf;
                            dbz_reg       <= alu_dbz;
                        end
                    end
                end
                BUSY: begin
                    hi_reg  <= hi_next;
                    lo_reg  <= lo_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_STEP) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= lo_next;
                        carry_reg     <= is_div_reg ? 1'b0 : (hi_next != '0);
                        zero_reg      <= (lo_next == '0);
                        sign_reg      <= lo_next[WIDTH-1];
                        overflow_reg  <= 1'b0;
                        dbz_reg       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign result      = result_reg;
    assign carry_out   = carry_reg;
    assign zero        = zero_reg;
    assign sign        = sign_reg;
    assign overflow    = overflow_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: doc/alu_seq_pipe.md
Name: alu_seq_pipe

Overview:
Parametrised, registered ALU for the 8085-style datapath. It extends the existing 8-bit opcode set to WIDTH bits and adds a valid/ready handshake on input and output. Multiply and divide run as iterative multi-cycle operations, and every result carries a full status-flag set (carry, zero, sign, overflow, divide-by-zero). It sits between the register file/operand mux and the accumulator writeback.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 4..32.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode bundle valid
in_ready  out  1  block can accept a bundle
operand_a  in  WIDTH  first operand (unsigned unless stated)
operand_b  in  WIDTH  second operand
operation  in  4  opcode; encoding below
out_valid  out  1  result bundle valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  operation result
carry_out  out  1  carry/borrow/shifted-out bit
zero  out  1  result == 0
sign  out  1  result[WIDTH-1]
overflow  out  1  two's-complement overflow (ADD/SUB only; 0 otherwise)
div_by_zero  out  1  DIV issued with operand_b == 0

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (quotient).
  - 4 SHL by 1, 5 SHR by 1 (logical), 6 ROL, 7 ROR.
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
  - E A>B (unsigned) -> 1/0, F A==B -> 1/0.
- carry_out:
  - ADD: bit WIDTH of the sum.
  - SUB: borrow, 1 when a<b unsigned.
  - MUL: 1 when the upper WIDTH bits of the 2*WIDTH product are nonzero.
  - DIV: 0.
  - SHL/ROL: operand_a[WIDTH-1]. SHR/ROR: operand_a[0].
  - Logic and compare ops: 0.
- overflow: ADD = a,b same sign and result sign differs; SUB = a,b differ in sign and result sign != a sign; 0 for all other ops.
- Flag timing: zero and sign are computed from the final result and registered together with it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands and opcode. Opcodes 2/3 go to BUSY with cnt=0; all others compute in one cycle and go to DONE.
  - BUSY: in_ready=0. One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. After WIDTH steps, go to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are stable while out_valid && !out_ready. On out_ready, go to IDLE.
- Latency, accept edge to first cycle of out_valid:
  - Single-cycle ops: 1 clk.
  - MUL/DIV: WIDTH+1 clk.
  - DIV with operand_b==0: skips BUSY, latency 1. result = all ones, carry_out=0, div_by_zero=1, zero=0, sign=1.
- Throughput: one operation in flight; no new bundle is accepted until DONE is consumed.
- Reset (rst_n low, asynchronous, valid at any state including mid-BUSY):
  - State goes to IDLE; any in-flight operation is discarded.
  - result=0, all flags=0, out_valid=0.
  - in_ready=1 from the first clock edge after rst_n deasserts.
- Input changes while in_ready=0 are ignored; operands are used only from the accept edge.
- The opcode set is fully decoded; there is no X output.
- Flags and result update only on the transition into DONE.

Test Plan:
- Reset mid-MUL: in cycle 3 of BUSY, pulse rst_n low -> out_valid=0, result=0, in_ready=1 after release; the next ADD 0x01+0x01 returns 0x02.
- ADD 0xFF+0x01, out_ready=1 (WIDTH=8) -> result 0x00, carry=1, zero=1, overflow=0, latency 1. ADD 0x7F+0x01 -> 0x80, sign=1, overflow=1, carry=0.
- SUB 0x03-0x05 -> 0xFE, carry(borrow)=1, sign=1. ROR 0x01 -> 0x80, carry=1. SHL 0x81 -> 0x02, carry=1.
- MUL 0x10*0x20 -> result 0x00, carry=1, zero=1, out_valid exactly 9 cycles after accept. MUL 0x0C*0x0B -> 0x84, carry=0.
- DIV 0xC8/0x07 -> 0x1C after 9 cycles. DIV 0x55/0x00 -> 0xFF, div_by_zero=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xAA^0x0F -> result 0xA5 stable, in_ready=0, new in_valid ignored. Then assert out_ready -> IDLE next cycle. Also run an equivalent MUL/DIV sweep at WIDTH=16 against a reference model.
